ts_tx_pacer: RTL and testbench

- Per-lane TX stage directly downstream of the LTSSM TS generator; one instance per lane.
- Accepts 128-bit TS words with a valid strobe into a small FIFO and advertises FIFO full back to the generator.
- Releases TS words on ts_o at the per-generation line rate: one TS every 64/32/16/8/4 clk cycles for Gen1..Gen5 at a 1GHz clk.

---
 rtl/ts_tx_pacer_if.sv | 27 ++
 rtl/ts_tx_pacer.sv | 159 +++++++++++++++
 tb/tb_ts_tx_pacer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_tx_pacer_if.sv
// ts_tx_pacer_if: TS generator write side and paced line side.
// master = generator/line model, slave = pacer.
interface ts_tx_pacer_if #(
   parameter int DEPTH = 4,
   parameter int DW    = 128
);
   logic [DW-1:0]            ts_i;
   logic                     ts_i_vld;
   logic                     ts_tx_fifo_full;
   logic                     wr_drop;
   logic [DW-1:0]            ts_o;
   logic                     ts_o_vld;
   logic                     ts_o_skp;
   logic [$clog2(DEPTH):0]   fifo_level;

   modport master (
      output ts_i, ts_i_vld,
      input  ts_tx_fifo_full, wr_drop,
      input  ts_o, ts_o_vld, ts_o_skp, fifo_level
   );

   modport slave (
      input  ts_i, ts_i_vld,
      output ts_tx_fifo_full, wr_drop,
      output ts_o, ts_o_vld, ts_o_skp, fifo_level
   );
endinterface

// File: rtl/ts_tx_pacer.sv
// ts_tx_pacer: per-lane TS FIFO releasing one word per line-rate slot.
// Optional SKP insertion is built when TS_TX_SKP_INS_EN is defined.
module ts_tx_pacer #(
   parameter int DEPTH        = 4,
   parameter int DW           = 128,
   parameter int SKP_INTERVAL = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [5:0]   speed,
   input  logic         flush,
   ts_tx_pacer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q;
   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_d;
   logic [5:0]    cnt_q;
   logic [5:0]    ivl;
   logic          full_q;
   logic          drop_q;
   logic          vld_q;
   logic [DW-1:0] ts_q;
   logic [DW-1:0] ts_nxt;
   logic          push;
   logic          pop;
   logic          emit;
   logic          skp_pend;
   logic          skp_now;

   // Slot length minus one; anything not a clean Gen2..Gen5 is Gen1
   always_comb begin
      ivl = 6'd63;
      case (speed)
         6'b000001: ivl = 6'd63;
         6'b000010: ivl = 6'd31;
         6'b000100: ivl = 6'd15;
         6'b001000: ivl = 6'd7;
         6'b010000: ivl = 6'd3;
         default:   ivl = 6'd63;
      endcase
   end

   // Open slot with a queued word emits; writes gated by advertised full
   always_comb begin
      emit = 1'b0;
      if (!flush && level_q != '0)
         emit = (state_q == IDLE) || (cnt_q == 6'd0);
      skp_now = emit && skp_pend;
      pop     = emit && !skp_now;
      push    = bus.ts_i_vld && !full_q && !flush;
      level_d = level_q + LW'(push) - LW'(pop);
   end

`ifdef TS_TX_SKP_INS_EN
   localparam int SW = $clog2(SKP_INTERVAL + 1);
   localparam logic [127:0] SKP_W = {8'hBC, 8'h1C, 8'h1C, 8'h1C, 96'h0};

   logic [SW-1:0] skp_cnt_q;
   logic          skp_q;

   assign skp_pend = (skp_cnt_q == SW'(SKP_INTERVAL));
   assign ts_nxt   = skp_now ? DW'(SKP_W) : mem_q[rd_ptr_q];

   // Count data words since the last SKP; SKP slots do not pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skp_cnt_q <= '0;
         skp_q     <= 1'b0;
      end else begin
         skp_q <= skp_now;
         if (flush || skp_now)
            skp_cnt_q <= '0;
         else if (pop)
            skp_cnt_q <= skp_cnt_q + SW'(1);
      end
   end

   assign bus.ts_o_skp = skp_q;
`else
   assign skp_pend     = 1'b0;
   assign ts_nxt       = mem_q[rd_ptr_q];
   assign bus.ts_o_skp = 1'b0;
`endif

   // FIFO storage; data array needs no reset
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= bus.ts_i;
   end

   // Pacer FSM, FIFO pointers and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         drop_q   <= 1'b0;
         vld_q    <= 1'b0;
         ts_q     <= '0;
      end else begin
         vld_q  <= 1'b0;
         drop_q <= bus.ts_i_vld && full_q && !flush;
         if (flush) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
         end else begin
            if (push)
               wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
               rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            full_q  <= (level_d == FULL_LVL);
            case (state_q)
               IDLE: begin
                  if (emit) begin
                     state_q <= RUN;
                     cnt_q   <= ivl;
                  end
               end
               RUN: begin
                  if (cnt_q != 6'd0)
                     cnt_q <= cnt_q - 6'd1;
                  else if (emit)
                     cnt_q <= ivl;
                  else
                     state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
            if (emit) begin
               vld_q <= 1'b1;
               ts_q  <= ts_nxt;
            end
         end
      end
   end

   assign bus.ts_o            = ts_q;
   assign bus.ts_o_vld        = vld_q;
   assign bus.wr_drop         = drop_q;
   assign bus.ts_tx_fifo_full = full_q;
   assign bus.fifo_level      = level_q;
endmodule

// File: tb/tb_ts_tx_pacer.sv
// tb_ts_tx_pacer: random and directed stimulus against a slot-time model.
// Define TS_TX_SKP_INS_EN for both RTL and bench to cover SKP insertion.
`timescale 1ns/100ps
module tb_ts_tx_pacer;
   localparam int DEPTH        = 4;
   localparam int DW           = 128;
   localparam int SKP_INTERVAL = 16;
   localparam logic [127:0] SKP_W = {8'hBC, 8'h1C, 8'h1C, 8'h1C, 96'h0};

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic [5:0] speed = 6'b000001;
   logic       flush = 1'b0;

   ts_tx_pacer_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

   ts_tx_pacer #(
      .DEPTH(DEPTH), .DW(DW), .SKP_INTERVAL(SKP_INTERVAL)
   ) dut (
      .clk(clk), .rst(rst), .speed(speed), .flush(flush), .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   logic [127:0] q[$];
   bit           running;
   int           last_emit;
   int           iv;
   int           credit;
   logic         exp_vld, exp_skp, exp_drop, exp_full;
   logic [127:0] exp_ts;
   int           exp_level;

   int vld_cyc[$];
   bit skp_seen[$];

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic int interval(input logic [5:0] s);
      case (s)
         6'b000010: return 32;
         6'b000100: return 16;
         6'b001000: return 8;
         6'b010000: return 4;
         default:   return 64;
      endcase
   endfunction

   function automatic logic [127:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      q.delete();
      running   = 0;
      last_emit = 0;
      iv        = 64;
      credit    = 0;
      exp_vld   = 0;
      exp_skp   = 0;
      exp_drop  = 0;
      exp_full  = 0;
      exp_ts    = '0;
      exp_level = 0;
   endtask

   // Predict the outputs of cycle cyc+1 from inputs held in cycle cyc
   task automatic model(input logic v, input logic [127:0] d,
                        input logic f, input logic [5:0] sp);
      int  lvl;
      bit  slot;
      lvl      = q.size();
      exp_vld  = 0;
      exp_skp  = 0;
      exp_drop = v && (lvl == DEPTH) && !f;
      if (f) begin
         q.delete();
         running   = 0;
         credit    = 0;
         exp_level = 0;
         exp_full  = 0;
         return;
      end
      slot = !running || (cyc == last_emit + iv - 1);
      if (running && slot && lvl == 0)
         running = 0;
      if (slot && lvl != 0) begin
         exp_vld   = 1;
         running   = 1;
         last_emit = cyc + 1;
         iv        = interval(sp);
`ifdef TS_TX_SKP_INS_EN
         if (credit == SKP_INTERVAL) begin
            exp_ts  = SKP_W;
            exp_skp = 1;
            credit  = 0;
         end else begin
            exp_ts = q.pop_front();
            credit++;
         end
`else
         exp_ts = q.pop_front();
`endif
      end
      if (v && lvl != DEPTH)
         q.push_back(d);
      exp_level = q.size();
      exp_full  = (q.size() == DEPTH);
   endtask

   task automatic check_outputs();
      chk("ts_o_vld", 128'(bus.ts_o_vld), 128'(exp_vld));
      chk("ts_o_skp", 128'(bus.ts_o_skp), 128'(exp_skp));
      chk("wr_drop", 128'(bus.wr_drop), 128'(exp_drop));
      chk("full", 128'(bus.ts_tx_fifo_full), 128'(exp_full));
      chk("level", 128'(bus.fifo_level), 128'(exp_level));
      chk("ts_o", bus.ts_o, exp_ts);
   endtask

   task automatic step(input logic v, input logic [127:0] d,
                       input logic f, input logic [5:0] sp);
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
      if (bus.ts_o_vld) begin
         vld_cyc.push_back(cyc);
         skp_seen.push_back(bus.ts_o_skp);
      end
      bus.ts_i_vld = v;
      bus.ts_i     = d;
      flush        = f;
      speed        = sp;
      model(v, d, f, sp);
   endtask

   task automatic idle(input int n, input logic [5:0] sp);
      for (int i = 0; i < n; i++)
         step(1'b0, '0, 1'b0, sp);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst          = 1'b0;
      bus.ts_i_vld = 1'b0;
      flush        = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic clear_log();
      vld_cyc.delete();
      skp_seen.delete();
   endtask

   logic [5:0] sp_tab [8];
   int         wc;
   int         sent;

   initial begin
      sp_tab[0] = 6'b000001; sp_tab[1] = 6'b000010;
      sp_tab[2] = 6'b000100; sp_tab[3] = 6'b001000;
      sp_tab[4] = 6'b010000; sp_tab[5] = 6'b100000;
      sp_tab[6] = 6'b000011; sp_tab[7] = 6'b000000;
      bus.ts_i     = '0;
      bus.ts_i_vld = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      rst = 1'b1;

      // Gen1: three consecutive writes, 64-cycle spacing
      idle(5, 6'b000001);
      clear_log();
      step(1'b1, rnd_word(), 1'b0, 6'b000001);
      wc = cyc;
      step(1'b1, rnd_word(), 1'b0, 6'b000001);
      step(1'b1, rnd_word(), 1'b0, 6'b000001);
      idle(200, 6'b000001);
      chk("gen1_pulses", 128'(vld_cyc.size()), 128'(3));
      chk("gen1_latency", 128'(vld_cyc[0]), 128'(wc + 2));
      chk("gen1_gap0", 128'(vld_cyc[1] - vld_cyc[0]), 128'(64));
      chk("gen1_gap1", 128'(vld_cyc[2] - vld_cyc[1]), 128'(64));

      // Gen5 burst of six writes into a four-entry FIFO
      clear_log();
      for (int i = 0; i < 6; i++)
         step(1'b1, rnd_word(), 1'b0, 6'b010000);
      idle(40, 6'b010000);
      chk("gen5_gap0", 128'(vld_cyc[1] - vld_cyc[0]), 128'(4));
      chk("gen5_gap2", 128'(vld_cyc[3] - vld_cyc[2]), 128'(4));

      // Gen1 to Gen3 switch while a slot is running
      clear_log();
      for (int i = 0; i < 3; i++)
         step(1'b1, rnd_word(), 1'b0, 6'b000001);
      idle(20, 6'b000001);
      idle(150, 6'b000100);
      chk("spd_gap_cur", 128'(vld_cyc[1] - vld_cyc[0]), 128'(64));
      chk("spd_gap_next", 128'(vld_cyc[2] - vld_cyc[1]), 128'(16));

      // flush together with a write while three words are queued
      for (int i = 0; i < 4; i++)
         step(1'b1, rnd_word(), 1'b0, 6'b000001);
      idle(3, 6'b000001);
      step(1'b1, rnd_word(), 1'b1, 6'b000001);
      idle(4, 6'b000001);
      clear_log();
      step(1'b1, rnd_word(), 1'b0, 6'b000001);
      wc = cyc;
      idle(6, 6'b000001);
      chk("flush_lat", 128'(vld_cyc[0]), 128'(wc + 2));
      idle(70, 6'b000001);

      // reserved and multi-hot speeds fall back to Gen1
      for (int s = 5; s <= 6; s++) begin
         clear_log();
         step(1'b1, rnd_word(), 1'b0, sp_tab[s]);
         step(1'b1, rnd_word(), 1'b0, sp_tab[s]);
         idle(140, sp_tab[s]);
         chk("bad_spd_gap", 128'(vld_cyc[1] - vld_cyc[0]), 128'(64));
      end

      // Gen4, twenty words kept flowing from a fresh reset
      do_reset();
      clear_log();
      sent = 0;
      for (int i = 0; i < 260; i++) begin
         if (sent < 20 && q.size() < DEPTH) begin
            step(1'b1, rnd_word(), 1'b0, 6'b001000);
            sent++;
         end else begin
            step(1'b0, '0, 1'b0, 6'b001000);
         end
      end
`ifdef TS_TX_SKP_INS_EN
      chk("g4_pulses", 128'(vld_cyc.size()), 128'(21));
      chk("g4_skp17", 128'(skp_seen[16]), 128'(1));
`else
      chk("g4_pulses", 128'(vld_cyc.size()), 128'(20));
`endif
      for (int i = 1; i < vld_cyc.size(); i++)
         chk("g4_gap", 128'(vld_cyc[i] - vld_cyc[i-1]), 128'(8));

      // random segments: speed, load, flush and async reset
      for (int seg = 0; seg < 40; seg++) begin
         logic [5:0] sp;
         int         pw;
         sp = sp_tab[$urandom_range(7)];
         pw = $urandom_range(100);
         if ($urandom_range(3) == 0)
            do_reset();
         for (int i = 0; i < 120; i++) begin
            logic v;
            logic f;
            v = ($urandom_range(99) < pw);
            f = ($urandom_range(63) == 0);
            if ($urandom_range(49) == 0)
               sp = sp_tab[$urandom_range(7)];
            step(v, rnd_word(), f, sp);
         end
      end

      idle(2, speed);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
